// File: rtl/branch_redirect_controller_pkg.sv
// Shared definitions for the branch redirect controller: FSM encoding, trap causes and
// bit positions on the execute-stage exception bus.
package branch_redirect_controller_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFlush    = 2'd1,
        StRedirect = 2'd2,
        StTrap     = 2'd3
    } brc_state_e;

    localparam logic [1:0] TRAP_CAUSE_NONE           = 2'd0;
    localparam logic [1:0] TRAP_CAUSE_ILLEGAL_BRANCH = 2'd1;
    localparam logic [1:0] TRAP_CAUSE_MISALIGNED     = 2'd2;

    localparam int unsigned EXC_ILLEGAL_BIT    = 3;
    localparam int unsigned EXC_MISPREDICT_BIT = 2;
    localparam int unsigned EXC_WORD_MIS_BIT   = 1;
    localparam int unsigned EXC_HALF_MIS_BIT   = 0;

endpackage

// File: rtl/redirect_perf_counters.sv
// Free-running jump and mispredict event counters; wrap modulo 2^32.
module redirect_perf_counters (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        jump_event_i,
    input  logic        mispredict_event_i,
    output logic [31:0] perf_jumps_o,
    output logic [31:0] perf_mispredicts_o
);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            perf_jumps_o       <= 32'd0;
            perf_mispredicts_o <= 32'd0;
        end else begin
            if (jump_event_i) begin
                perf_jumps_o <= perf_jumps_o + 32'd1;
            end
            if (mispredict_event_i) begin
                perf_mispredicts_o <= perf_mispredicts_o + 32'd1;
            end
        end
    end

endmodule

// File: rtl/branch_redirect_controller.sv
// Pipeline recovery sequencer after jump resolution: flush, redirect fetch, or raise a trap.
// Optional performance counters are enabled by defining BRANCH_REDIRECT_PERF_EN.
module branch_redirect_controller
    import branch_redirect_controller_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              resolve_valid_i,
    input  logic              resolve_jump_i,
    input  logic [3:0]        resolve_exception_i,
    input  logic [ADDR_W-1:0] resolve_target_i,
    input  logic [ADDR_W-1:0] resolve_pc_i,
    input  logic              fetch_ready_i,
    input  logic              trap_ready_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              trap_valid_o,
    output logic [1:0]        trap_cause_o,
    output logic [ADDR_W-1:0] trap_pc_o,
`ifdef BRANCH_REDIRECT_PERF_EN
    output logic [31:0]       perf_jumps_o,
    output logic [31:0]       perf_mispredicts_o,
`endif
    output logic              busy_o
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    brc_state_e state_q;
    logic [3:0] cnt_q;
    logic       accept;
    logic       take_illegal;
    logic       take_misalign;
    logic       take_mispredict;

    // Fixed priority: illegal > misaligned > mispredict.
    always_comb begin
        accept          = (state_q == StIdle) && resolve_valid_i;
        take_illegal    = accept && resolve_exception_i[EXC_ILLEGAL_BIT];
        take_misalign   = accept && !resolve_exception_i[EXC_ILLEGAL_BIT] && resolve_jump_i &&
                          (resolve_exception_i[EXC_WORD_MIS_BIT] ||
                           resolve_exception_i[EXC_HALF_MIS_BIT]);
        take_mispredict = accept && !take_illegal && !take_misalign && resolve_jump_i &&
                          resolve_exception_i[EXC_MISPREDICT_BIT];
    end

    // redirect_addr_o doubles as the latched target; only updated on entry to FLUSH.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q          <= StIdle;
            cnt_q            <= 4'd0;
            stall_o          <= 1'b0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_addr_o  <= '0;
            trap_valid_o     <= 1'b0;
            trap_cause_o     <= TRAP_CAUSE_NONE;
            trap_pc_o        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (take_illegal || take_misalign) begin
                        state_q      <= StTrap;
                        trap_valid_o <= 1'b1;
                        flush_o      <= 1'b1;
                        stall_o      <= 1'b1;
                        trap_cause_o <= take_illegal ? TRAP_CAUSE_ILLEGAL_BRANCH
                                                     : TRAP_CAUSE_MISALIGNED;
                        trap_pc_o    <= resolve_pc_i;
                    end else if (take_mispredict) begin
                        state_q         <= StFlush;
                        flush_o         <= 1'b1;
                        stall_o         <= 1'b1;
                        cnt_q           <= CNT_LOAD;
                        redirect_addr_o <= resolve_target_i;
                    end
                end
                StFlush: begin
                    if (cnt_q == 4'd0) begin
                        state_q          <= StRedirect;
                        flush_o          <= 1'b0;
                        redirect_valid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRedirect: begin
                    if (fetch_ready_i) begin
                        state_q          <= StIdle;
                        redirect_valid_o <= 1'b0;
                        stall_o          <= 1'b0;
                    end
                end
                StTrap: begin
                    if (trap_ready_i) begin
                        state_q      <= StIdle;
                        trap_valid_o <= 1'b0;
                        flush_o      <= 1'b0;
                        stall_o      <= 1'b0;
                        trap_cause_o <= TRAP_CAUSE_NONE;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = stall_o;

`ifdef BRANCH_REDIRECT_PERF_EN
    redirect_perf_counters u_perf (
        .clock_i            (clock_i),
        .resetn_i           (resetn_i),
        .jump_event_i       (accept && resolve_jump_i),
        .mispredict_event_i (take_mispredict),
        .perf_jumps_o       (perf_jumps_o),
        .perf_mispredicts_o (perf_mispredicts_o)
    );
`endif

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Directed self-checking bench for branch_redirect_controller (FLUSH_CYCLES=2, ADDR_W=32).
module tb_branch_redirect_controller;

    logic        clock_i;
    logic        resetn_i;
    logic        resolve_valid_i;
    logic        resolve_jump_i;
    logic [3:0]  resolve_exception_i;
    logic [31:0] resolve_target_i;
    logic [31:0] resolve_pc_i;
    logic        fetch_ready_i;
    logic        trap_ready_i;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_addr_o;
    logic        trap_valid_o;
    logic [1:0]  trap_cause_o;
    logic [31:0] trap_pc_o;
    logic        busy_o;
`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0] perf_jumps_o;
    logic [31:0] perf_mispredicts_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    branch_redirect_controller #(
        .FLUSH_CYCLES (2),
        .ADDR_W       (32)
    ) dut (
        .clock_i             (clock_i),
        .resetn_i            (resetn_i),
        .resolve_valid_i     (resolve_valid_i),
        .resolve_jump_i      (resolve_jump_i),
        .resolve_exception_i (resolve_exception_i),
        .resolve_target_i    (resolve_target_i),
        .resolve_pc_i        (resolve_pc_i),
        .fetch_ready_i       (fetch_ready_i),
        .trap_ready_i        (trap_ready_i),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_addr_o     (redirect_addr_o),
        .trap_valid_o        (trap_valid_o),
        .trap_cause_o        (trap_cause_o),
        .trap_pc_o           (trap_pc_o),
`ifdef BRANCH_REDIRECT_PERF_EN
        .perf_jumps_o        (perf_jumps_o),
        .perf_mispredicts_o  (perf_mispredicts_o),
`endif
        .busy_o              (busy_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares {stall, flush, redirect_valid, trap_valid, busy}; busy must track stall.
    task automatic chk_ctl(input string tag, input logic s, input logic f, input logic r,
                           input logic t);
        chk(tag, {27'd0, stall_o, flush_o, redirect_valid_o, trap_valid_o, busy_o},
            {27'd0, s, f, r, t, s});
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic resolve(input logic v, input logic j, input logic [3:0] exc,
                           input logic [31:0] tgt, input logic [31:0] pc);
        resolve_valid_i     = v;
        resolve_jump_i      = j;
        resolve_exception_i = exc;
        resolve_target_i    = tgt;
        resolve_pc_i        = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn_i      = 1'b0;
        fetch_ready_i = 1'b0;
        trap_ready_i  = 1'b0;
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);

        // Reset state
        step();
        step();
        chk_ctl("reset_ctl", 0, 0, 0, 0);
        chk("reset_addr", redirect_addr_o, 32'h0);
        chk("reset_cause", {30'd0, trap_cause_o}, 32'd0);
        chk("reset_tpc", trap_pc_o, 32'h0);
        resetn_i = 1'b1;
        step();
        chk_ctl("post_reset_idle", 0, 0, 0, 0);

        // Mispredict, fetch ready immediately
        fetch_ready_i = 1'b1;
        resolve(1'b1, 1'b1, 4'b0100, 32'h0000_1040, 32'h100);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("mp_flush1", 1, 1, 0, 0);
        step();
        chk_ctl("mp_flush2", 1, 1, 0, 0);
        step();
        chk_ctl("mp_redirect", 1, 0, 1, 0);
        chk("mp_addr", redirect_addr_o, 32'h0000_1040);
        step();
        chk_ctl("mp_idle", 0, 0, 0, 0);

        // Backpressure; a bogus illegal resolve is held throughout and must be ignored
        fetch_ready_i = 1'b0;
        resolve(1'b1, 1'b1, 4'b0100, 32'h0000_2080, 32'h104);
        step();
        resolve(1'b1, 1'b0, 4'b1000, 32'h0, 32'hdead);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk_ctl("bp_redirect_hold", 1, 0, 1, 0);
            chk("bp_addr_hold", redirect_addr_o, 32'h0000_2080);
            step();
        end
        fetch_ready_i = 1'b1;
        chk_ctl("bp_ready_cycle", 1, 0, 1, 0);
        step();
        chk_ctl("bp_released", 0, 0, 0, 0);
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step();
        chk_ctl("bp_no_back_to_back", 0, 0, 0, 0);

        // Correct jump: no recovery
        resolve(1'b1, 1'b1, 4'b0000, 32'h0000_0500, 32'h180);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("good_jump_idle", 0, 0, 0, 0);

        // Priority: illegal beats misaligned and mispredict
        trap_ready_i = 1'b0;
        resolve(1'b1, 1'b1, 4'b1110, 32'h0000_3000, 32'h200);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("pri_trap", 1, 1, 0, 1);
        chk("pri_cause", {30'd0, trap_cause_o}, 32'd1);
        chk("pri_tpc", trap_pc_o, 32'h200);
        step();
        chk_ctl("pri_trap_hold", 1, 1, 0, 1);
        chk("pri_cause_hold", {30'd0, trap_cause_o}, 32'd1);
        trap_ready_i = 1'b1;
        step();
        chk_ctl("pri_trap_done", 0, 0, 0, 0);

        // Misaligned target trap, ready already high: one-cycle valid
        resolve(1'b1, 1'b1, 4'b0101, 32'h0000_3002, 32'h204);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("mis_trap", 1, 1, 0, 1);
        chk("mis_cause", {30'd0, trap_cause_o}, 32'd2);
        chk("mis_tpc", trap_pc_o, 32'h204);
        step();
        chk_ctl("mis_one_cycle", 0, 0, 0, 0);

        // Misaligned outranks mispredict
        resolve(1'b1, 1'b1, 4'b0110, 32'h0000_3006, 32'h20c);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk("mis_over_mp_cause", {30'd0, trap_cause_o}, 32'd2);
        chk_ctl("mis_over_mp_ctl", 1, 1, 0, 1);
        step();

        // Non-jump with misaligned or mispredict bits: ignored
        resolve(1'b1, 1'b0, 4'b0011, 32'h0000_3001, 32'h210);
        step();
        chk_ctl("nojump_mis_idle", 0, 0, 0, 0);
        resolve(1'b1, 1'b0, 4'b0100, 32'h0000_3100, 32'h214);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("nojump_mp_idle", 0, 0, 0, 0);

        // Illegal func3 traps regardless of jump flag
        resolve(1'b1, 1'b0, 4'b1000, 32'h0, 32'h208);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("ill_nojump_trap", 1, 1, 0, 1);
        chk("ill_nojump_cause", {30'd0, trap_cause_o}, 32'd1);
        chk("ill_nojump_tpc", trap_pc_o, 32'h208);
        step();
        chk_ctl("ill_nojump_done", 0, 0, 0, 0);

        // Reset during first flush cycle
        fetch_ready_i = 1'b1;
        resolve(1'b1, 1'b1, 4'b0100, 32'h0000_4000, 32'h300);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        chk_ctl("rst_mid_flush1", 1, 1, 0, 0);
        resetn_i = 1'b0;
        #1;
        chk_ctl("rst_mid_async", 0, 0, 0, 0);
        chk("rst_mid_addr", redirect_addr_o, 32'h0);
        step();
        resetn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_ctl("rst_mid_no_redirect", 0, 0, 0, 0);
        end

`ifdef BRANCH_REDIRECT_PERF_EN
        chk("perf_jumps_reset", perf_jumps_o, 32'd0);
        chk("perf_mp_reset", perf_mispredicts_o, 32'd0);
        for (int i = 0; i < 3; i++) begin
            resolve(1'b1, 1'b1, 4'b0000, 32'h0000_6000, 32'h400);
            step();
        end
        resolve(1'b1, 1'b1, 4'b0100, 32'h0000_5000, 32'h40c);
        step();
        resolve(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        step();
        step();
        chk_ctl("perf_redirect", 1, 0, 1, 0);
        step();
        chk("perf_jumps", perf_jumps_o, 32'd4);
        chk("perf_mispredicts", perf_mispredicts_o, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
